// File: rtl/dm_waitstate.sv
// Data memory for the pipelined MIPS core with a Req/Busy/Done handshake and a
// fixed number of wait states. It supports word/half/byte accesses and flags bad ones.
module dm_waitstate #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [2:0]  LStype,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RD,
    output logic        AddrErr
);

    localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, FIN} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wd_q;
    logic                    we_q;
    logic [2:0]              lsType_q;
    logic                    err_q;
    logic [31:0]             rd_q;
    logic                    addrErr_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    accept, enterFin;
    logic [ADDR_WIDTH-1:0]   cAddr;
    logic [31:0]             cWd;
    logic                    cWe;
    logic [2:0]              cType;
    logic                    cErr;
    logic [ADDR_WIDTH-3:0]   wordIdx;
    logic [31:0]             oldWord, mergedWord, loadWord;
    logic [15:0]             halfLane;
    logic [7:0]              byteLane;

    function automatic logic accessErr(input logic [31:0] a, input logic [2:0] t);
        logic misaligned, outOfRange, illegal;
        misaligned = ((t == 3'b000) && (a[1:0] != 2'b00)) ||
                     (((t == 3'b001) || (t == 3'b010)) && a[0]);
        outOfRange = (a[31:ADDR_WIDTH] != '0);
        illegal    = (t > 3'b100);
        return misaligned || outOfRange || illegal;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        enterFin = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                if (Req) begin
                    accept = 1'b1;
                    cnt_d  = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = FIN;
                        enterFin = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d  = FIN;
                    enterFin = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With no wait states the commit happens on the accepting edge itself,
    // so the live request is used instead of the latched copy.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            cAddr = Addr[ADDR_WIDTH-1:0];
            cWd   = WD;
            cWe   = WE;
            cType = LStype;
            cErr  = accessErr(Addr, LStype);
        end else begin
            cAddr = addr_q;
            cWd   = wd_q;
            cWe   = we_q;
            cType = lsType_q;
            cErr  = err_q;
        end
    end

    always_comb begin
        wordIdx  = cAddr[ADDR_WIDTH-1:2];
        oldWord  = mem_q[wordIdx];
        halfLane = cAddr[1] ? oldWord[31:16] : oldWord[15:0];
        case (cAddr[1:0])
            2'd0:    byteLane = oldWord[7:0];
            2'd1:    byteLane = oldWord[15:8];
            2'd2:    byteLane = oldWord[23:16];
            default: byteLane = oldWord[31:24];
        endcase

        mergedWord = oldWord;
        case (cType)
            3'b000: mergedWord = cWd;
            3'b001, 3'b010: begin
                if (cAddr[1]) mergedWord[31:16] = cWd[15:0];
                else          mergedWord[15:0]  = cWd[15:0];
            end
            3'b011, 3'b100: begin
                case (cAddr[1:0])
                    2'd0:    mergedWord[7:0]   = cWd[7:0];
                    2'd1:    mergedWord[15:8]  = cWd[7:0];
                    2'd2:    mergedWord[23:16] = cWd[7:0];
                    default: mergedWord[31:24] = cWd[7:0];
                endcase
            end
            default: mergedWord = oldWord;
        endcase

        case (cType)
            3'b000:  loadWord = oldWord;
            3'b001:  loadWord = {{16{halfLane[15]}}, halfLane};
            3'b010:  loadWord = {16'h0000, halfLane};
            3'b011:  loadWord = {{24{byteLane[7]}}, byteLane};
            3'b100:  loadWord = {24'h000000, byteLane};
            default: loadWord = 32'h0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            we_q      <= 1'b0;
            lsType_q  <= '0;
            err_q     <= 1'b0;
            rd_q      <= '0;
            addrErr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= Addr[ADDR_WIDTH-1:0];
                wd_q     <= WD;
                we_q     <= WE;
                lsType_q <= LStype;
                err_q    <= accessErr(Addr, LStype);
            end
            if (enterFin) begin
                addrErr_q <= cErr;
                rd_q      <= (cErr || cWe) ? 32'h0 : loadWord;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (enterFin && cWe && !cErr) begin
            mem_q[wordIdx] <= mergedWord;
        end
    end

    assign Busy    = (state_q == WAIT);
    assign Done    = (state_q == FIN);
    assign RD      = rd_q;
    assign AddrErr = addrErr_q;

endmodule

// File: tb/tb_dm_waitstate.sv
// Directed bench for dm_waitstate: a vector table for single transactions plus
// hand-written sequences for back-to-back issue, zero wait states and reset.
module tb_dm_waitstate;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req, WE;
    logic [31:0] Addr, WD;
    logic [2:0]  LStype;
    logic        Busy, Done, AddrErr;
    logic [31:0] RD;

    logic        req0, we0;
    logic [31:0] addr0, wd0;
    logic [2:0]  lst0;
    logic        busy0, done0, err0;
    logic [31:0] rd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  lsType;
        logic [31:0] expRd;
        logic        expErr;
        bit          glitch;
    } vec_t;

    vec_t vecs[$];

    dm_waitstate #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .Addr(Addr), .WD(WD),
        .LStype(LStype), .Busy(Busy), .Done(Done), .RD(RD), .AddrErr(AddrErr)
    );

    dm_waitstate #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(req0), .WE(we0), .Addr(addr0), .WD(wd0),
        .LStype(lst0), .Busy(busy0), .Done(done0), .RD(rd0), .AddrErr(err0)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request on the W=2 instance starting at a negedge and returns
    // at the negedge of the Done cycle; optionally pokes Req during WAIT.
    task automatic applyStimulus(input vec_t v, input string name);
        int k;
        bit seen, busyOk;
        Req = 1'b1; WE = v.we; Addr = v.addr; WD = v.wd; LStype = v.lsType;
        @(posedge Clk);
        seen = 1'b0; busyOk = 1'b1; k = 0;
        while (!seen && k < 20) begin
            @(negedge Clk);
            k++;
            if (Done) seen = 1'b1;
            else if (!Busy) busyOk = 1'b0;
            if (k == 1 && v.glitch) begin
                Req = 1'b1; WE = ~v.we; Addr = v.addr ^ 32'h4; WD = ~v.wd; LStype = 3'b000;
            end else begin
                Req = 1'b0;
            end
        end
        checkOutput({name, ".latency"}, 32'(k), 32'd3);
        checkOutput({name, ".busy"}, {31'b0, busyOk}, 32'd1);
        if (seen) begin
            checkOutput({name, ".busyInFin"}, {31'b0, Busy}, 32'd0);
            checkOutput({name, ".rd"}, RD, v.expRd);
            checkOutput({name, ".err"}, {31'b0, AddrErr}, {31'b0, v.expErr});
        end
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b0; WE = 1'b0; Addr = '0; WD = '0; LStype = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0; lst0 = '0;

        vecs.push_back('{1'b1, 32'h0000, 32'h11223344, 3'b000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h0010, 32'h89ABCDEF, 3'b000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b000, 32'h89ABCDEF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0012, 32'h0,        3'b001, 32'hFFFF89AB, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0012, 32'h0,        3'b010, 32'h000089AB, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0011, 32'h0,        3'b011, 32'hFFFFFFCD, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0013, 32'h0,        3'b100, 32'h00000089, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b010, 32'h0000CDEF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b011, 32'hFFFFFFEF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h0011, 32'h000000AA, 3'b011, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b000, 32'h89ABAAEF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h0012, 32'h00001234, 3'b001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b000, 32'h1234AAEF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h0013, 32'hFFFFFF77, 3'b100, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b000, 32'h7734AAEF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0013, 32'h0,        3'b000, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h2000, 32'hDEADBEEF, 3'b000, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h0000, 32'h0,        3'b000, 32'h11223344, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b111, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h0011, 32'h0000FFFF, 3'b010, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h0010, 32'h00000000, 3'b101, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b000, 32'h7734AAEF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h1000, 32'h0,        3'b000, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h0030, 32'hCAFEF00D, 3'b000, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'h0030, 32'h0,        3'b000, 32'hCAFEF00D, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0034, 32'h0,        3'b000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0013, 32'h0,        3'b011, 32'h00000077, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h0010, 32'h0,        3'b001, 32'hFFFFAAEF, 1'b0, 1'b0});

        repeat (2) @(negedge Clk);
        checkOutput("reset.busy", {31'b0, Busy}, 32'd0);
        checkOutput("reset.done", {31'b0, Done}, 32'd0);
        checkOutput("reset.rd", RD, 32'd0);
        checkOutput("reset.err", {31'b0, AddrErr}, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Req held high: a new load is accepted in every FIN cycle.
        @(negedge Clk);
        Req = 1'b1; WE = 1'b0; Addr = 32'h10; LStype = 3'b000;
        @(posedge Clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("held.done%0d", k), {31'b0, Done},
                        {31'b0, (k % 3 == 0)});
            if (k % 3 == 0) checkOutput($sformatf("held.rd%0d", k), RD, 32'h7734AAEF);
            if (k == 9) Req = 1'b0;
        end

        // Zero-wait instance: Done in the cycle right after acceptance.
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wd0 = 32'h00005A5A; lst0 = 3'b000;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("w0.storeDone", {31'b0, done0}, 32'd1);
        checkOutput("w0.storeBusy", {31'b0, busy0}, 32'd0);
        checkOutput("w0.storeErr", {31'b0, err0}, 32'd0);
        we0 = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("w0.loadDone", {31'b0, done0}, 32'd1);
        checkOutput("w0.loadRd", rd0, 32'h00005A5A);
        req0 = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("w0.idleDone", {31'b0, done0}, 32'd0);
        req0 = 1'b1; addr0 = 32'h5; lst0 = 3'b011;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("w0.lbRd", rd0, 32'h0000005A);
        req0 = 1'b0;

        // Reset in the WAIT cycle of a store aborts it without a Done pulse.
        @(negedge Clk);
        Req = 1'b1; WE = 1'b1; Addr = 32'h20; WD = 32'h55; LStype = 3'b000;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst.busyBefore", {31'b0, Busy}, 32'd1);
        Req = 1'b0; Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst.busy", {31'b0, Busy}, 32'd0);
        checkOutput("rst.done", {31'b0, Done}, 32'd0);
        checkOutput("rst.rd", RD, 32'd0);
        checkOutput("rst.err", {31'b0, AddrErr}, 32'd0);
        checkOutput("rst.rd0", rd0, 32'd0);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("rst.noDone%0d", k), {31'b0, Done}, 32'd0);
        end
        applyStimulus('{1'b0, 32'h0020, 32'h0, 3'b000, 32'h00000000, 1'b0, 1'b0}, "rst.lw20");
        applyStimulus('{1'b0, 32'h0010, 32'h0, 3'b000, 32'h00000000, 1'b0, 1'b0}, "rst.lw10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
